// File: rtl/id_stage_regfile.sv
// id_stage_regfile: instruction decode stage for the ARM-subset pipeline.
//
// Decodes the IF instruction, reads two operands from the register file
// (with write-through from the WB port), evaluates the condition field
// against NZCV and registers the result into the ID/EX boundary.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   pc_in, instr_in, in_valid  instruction from IF
//   stall, flush             ID/EX hold / bubble insertion (flush wins)
//   nzcv                     {N,Z,C,V} from the status register
//   wb_en, wb_dest, wb_value register file write port from WB
//   hz_src1, hz_src2, hz_two_src  combinational source indices for hazards
//   ex_*                     registered ID/EX outputs
module id_stage_regfile #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_COUNT    = 16,
    parameter int EXEC_CMD_LEN = 4,
    localparam int RIDX        = $clog2(REG_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pc_in,
    input  logic [31:0]             instr_in,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [3:0]              nzcv,
    input  logic                    wb_en,
    input  logic [RIDX-1:0]         wb_dest,
    input  logic [DATA_WIDTH-1:0]   wb_value,
    output logic [RIDX-1:0]         hz_src1,
    output logic [RIDX-1:0]         hz_src2,
    output logic                    hz_two_src,
    output logic                    ex_valid,
    output logic [DATA_WIDTH-1:0]   ex_pc,
    output logic [EXEC_CMD_LEN-1:0] ex_cmd,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_wb_en,
    output logic                    ex_branch,
    output logic                    ex_s,
    output logic                    ex_imm,
    output logic [DATA_WIDTH-1:0]   ex_val_rn,
    output logic [DATA_WIDTH-1:0]   ex_val_src2,
    output logic [11:0]             ex_shift_op,
    output logic [23:0]             ex_imm24,
    output logic [RIDX-1:0]         ex_dest,
    output logic [RIDX-1:0]         ex_src1,
    output logic [RIDX-1:0]         ex_src2
);

    // One bit wider than an index so the limit itself is representable.
    localparam logic [RIDX:0] REG_LIMIT = (RIDX+1)'(REG_COUNT);

    function automatic logic idx_ok(input logic [RIDX-1:0] idx);
        return {1'b0, idx} < REG_LIMIT;
    endfunction

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic [3:0]      cond;
    logic [1:0]      mode;
    logic            i_bit;
    logic [3:0]      opcode;
    logic            s_bit;
    logic [RIDX-1:0] rn, rd, rm;
    logic            is_str;
    logic            wb_ok;
    logic            cond_ok;

    logic [EXEC_CMD_LEN-1:0] dec_cmd;
    logic dec_mem_read, dec_mem_write, dec_wb_en, dec_branch, dec_s;
    logic [DATA_WIDTH-1:0] val_rn, val_src2;

    assign cond   = instr_in[31:28];
    assign mode   = instr_in[27:26];
    assign i_bit  = instr_in[25];
    assign opcode = instr_in[24:21];
    assign s_bit  = instr_in[20];
    assign rn     = RIDX'(instr_in[19:16]);
    assign rd     = RIDX'(instr_in[15:12]);
    assign rm     = RIDX'(instr_in[3:0]);

    // STR reads Rd as its store data, so it is the second source.
    assign is_str     = (mode == 2'b01) && !s_bit;
    assign hz_src1    = rn;
    assign hz_src2    = is_str ? rd : rm;
    assign hz_two_src = in_valid && (is_str || (mode == 2'b00 && !i_bit));

    assign wb_ok = wb_en && idx_ok(wb_dest);

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = !z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = !c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = !n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = !v;
            4'b1000: cond_ok = c && !z;
            4'b1001: cond_ok = !c || z;
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = !z && (n == v);
            4'b1101: cond_ok = z || (n != v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_cmd       = '0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_wb_en     = 1'b0;
        dec_branch    = 1'b0;
        dec_s         = 1'b0;
        case (mode)
            2'b00: begin
                dec_s     = s_bit;
                dec_wb_en = 1'b1;
                case (opcode)
                    4'b1101: dec_cmd = EXEC_CMD_LEN'(4'b0001);
                    4'b1111: dec_cmd = EXEC_CMD_LEN'(4'b1001);
                    4'b0100: dec_cmd = EXEC_CMD_LEN'(4'b0010);
                    4'b0101: dec_cmd = EXEC_CMD_LEN'(4'b0011);
                    4'b0010: dec_cmd = EXEC_CMD_LEN'(4'b0100);
                    4'b0110: dec_cmd = EXEC_CMD_LEN'(4'b0101);
                    4'b0000: dec_cmd = EXEC_CMD_LEN'(4'b0110);
                    4'b1100: dec_cmd = EXEC_CMD_LEN'(4'b0111);
                    4'b0001: dec_cmd = EXEC_CMD_LEN'(4'b1000);
                    4'b1010: begin
                        dec_cmd   = EXEC_CMD_LEN'(4'b0100);
                        dec_wb_en = 1'b0;
                    end
                    4'b1000: begin
                        dec_cmd   = EXEC_CMD_LEN'(4'b0110);
                        dec_wb_en = 1'b0;
                    end
                    default: dec_wb_en = 1'b0;
                endcase
            end
            2'b01: begin
                dec_cmd = EXEC_CMD_LEN'(4'b0010);
                if (s_bit) begin
                    dec_mem_read = 1'b1;
                    dec_wb_en    = 1'b1;
                end else begin
                    dec_mem_write = 1'b1;
                end
            end
            2'b10: dec_branch = 1'b1;
            default: ;
        endcase
        if (!cond_ok) begin
            dec_cmd       = '0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_wb_en     = 1'b0;
            dec_branch    = 1'b0;
            dec_s         = 1'b0;
        end
    end

    // Operand reads; a same-cycle WB write to the same index wins.
    always_comb begin
        val_rn   = '0;
        val_src2 = '0;
        if (idx_ok(rn))      val_rn   = regs[rn];
        if (idx_ok(hz_src2)) val_src2 = regs[hz_src2];
        if (wb_ok && wb_dest == rn)      val_rn   = wb_value;
        if (wb_ok && wb_dest == hz_src2) val_src2 = wb_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_cmd       <= '0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_wb_en     <= 1'b0;
            ex_branch    <= 1'b0;
            ex_s         <= 1'b0;
            ex_imm       <= 1'b0;
            ex_val_rn    <= '0;
            ex_val_src2  <= '0;
            ex_shift_op  <= '0;
            ex_imm24     <= '0;
            ex_dest      <= '0;
            ex_src1      <= '0;
            ex_src2      <= '0;
        end else if (!stall) begin
            ex_valid     <= in_valid;
            ex_pc        <= pc_in;
            ex_cmd       <= in_valid ? dec_cmd : '0;
            ex_mem_read  <= in_valid && dec_mem_read;
            ex_mem_write <= in_valid && dec_mem_write;
            ex_wb_en     <= in_valid && dec_wb_en;
            ex_branch    <= in_valid && dec_branch;
            ex_s         <= in_valid && dec_s;
            ex_imm       <= in_valid && i_bit;
            ex_val_rn    <= val_rn;
            ex_val_src2  <= val_src2;
            ex_shift_op  <= instr_in[11:0];
            ex_imm24     <= instr_in[23:0];
            ex_dest      <= rd;
            ex_src1      <= rn;
            ex_src2      <= hz_src2;
        end
    end

endmodule

// File: tb/tb_id_stage_regfile.sv
// tb_id_stage_regfile: directed bench for id_stage_regfile with an
// instruction-level reference model and a per-cycle compare process.
module tb_id_stage_regfile;

    localparam int RC = 16;

    logic        clk, rst;
    logic [31:0] pc_in, instr_in;
    logic        in_valid, stall, flush;
    logic [3:0]  nzcv;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  hz_src1, hz_src2;
    logic        hz_two_src;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_cmd;
    logic        ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, ex_imm;
    logic [31:0] ex_val_rn, ex_val_src2;
    logic [11:0] ex_shift_op;
    logic [23:0] ex_imm24;
    logic [3:0]  ex_dest, ex_src1, ex_src2;

    int checks = 0;
    int errors = 0;

    id_stage_regfile dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .in_valid(in_valid), .stall(stall), .flush(flush), .nzcv(nzcv),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .hz_src1(hz_src1), .hz_src2(hz_src2), .hz_two_src(hz_two_src),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_cmd(ex_cmd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_wb_en(ex_wb_en), .ex_branch(ex_branch), .ex_s(ex_s),
        .ex_imm(ex_imm), .ex_val_rn(ex_val_rn), .ex_val_src2(ex_val_src2),
        .ex_shift_op(ex_shift_op), .ex_imm24(ex_imm24), .ex_dest(ex_dest),
        .ex_src1(ex_src1), .ex_src2(ex_src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        mr, mw, wb, br, s, imm;
        logic [31:0] vrn, vs2;
        logic [11:0] shift;
        logic [23:0] imm24;
        logic [3:0]  dest, src1, src2;
    } ex_t;

    ex_t         exp_ex;
    logic [31:0] mregs [RC];

    function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;        1: return !z;
            2: return cy;       3: return !cy;
            4: return n;        5: return !n;
            6: return v;        7: return !v;
            8: return cy & !z;  9: return !cy | z;
            10: return n == v;  11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Mnemonic table for data processing: {command, writes Rd}.
    function automatic logic [4:0] dp_entry(input logic [3:0] op);
        case (op)
            4'hD: return {4'h1, 1'b1};  // MOV
            4'hF: return {4'h9, 1'b1};  // MVN
            4'h4: return {4'h2, 1'b1};  // ADD
            4'h5: return {4'h3, 1'b1};  // ADC
            4'h2: return {4'h4, 1'b1};  // SUB
            4'h6: return {4'h5, 1'b1};  // SBC
            4'h0: return {4'h6, 1'b1};  // AND
            4'hC: return {4'h7, 1'b1};  // ORR
            4'h1: return {4'h8, 1'b1};  // EOR
            4'hA: return {4'h4, 1'b0};  // CMP
            4'h8: return {4'h6, 1'b0};  // TST
            default: return 5'b0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] idx);
        if (wb_en && wb_dest == idx) return wb_value;
        return mregs[idx];
    endfunction

    function automatic logic [3:0] exp_src2(input logic [31:0] ins);
        return (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
    endfunction

    function automatic logic exp_two(input logic [31:0] ins, input logic v);
        return v && ((ins[27:26] == 2'b01 && !ins[20]) || (ins[27:26] == 2'b00 && !ins[25]));
    endfunction

    function automatic ex_t model_next();
        ex_t e;
        logic [4:0] d;
        e       = '0;
        e.valid = in_valid;
        e.pc    = pc_in;
        e.shift = instr_in[11:0];
        e.imm24 = instr_in[23:0];
        e.dest  = instr_in[15:12];
        e.src1  = instr_in[19:16];
        e.src2  = exp_src2(instr_in);
        e.vrn   = mread(e.src1);
        e.vs2   = mread(e.src2);
        e.imm   = in_valid && instr_in[25];
        if (in_valid && passes(instr_in[31:28], nzcv)) begin
            case (instr_in[27:26])
                2'b00: begin
                    d     = dp_entry(instr_in[24:21]);
                    e.cmd = d[4:1];
                    e.wb  = d[0];
                    e.s   = instr_in[20];
                end
                2'b01: begin
                    e.cmd = 4'h2;
                    e.mr  = instr_in[20];
                    e.wb  = instr_in[20];
                    e.mw  = !instr_in[20];
                end
                2'b10: e.br = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_ex = '0;
            for (int i = 0; i < RC; i++) mregs[i] = '0;
        end else begin
            if (flush) exp_ex = '0;
            else if (!stall) exp_ex = model_next();
            if (wb_en && int'(wb_dest) < RC) mregs[wb_dest] = wb_value;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("hz_src1", hz_src1, instr_in[19:16]);
            chk("hz_src2", hz_src2, exp_src2(instr_in));
            chk("hz_two_src", hz_two_src, exp_two(instr_in, in_valid));
            chk("ex_valid", ex_valid, exp_ex.valid);
            chk("ex_cmd", ex_cmd, exp_ex.cmd);
            chk("ex_mem_read", ex_mem_read, exp_ex.mr);
            chk("ex_mem_write", ex_mem_write, exp_ex.mw);
            chk("ex_wb_en", ex_wb_en, exp_ex.wb);
            chk("ex_branch", ex_branch, exp_ex.br);
            chk("ex_s", ex_s, exp_ex.s);
            chk("ex_imm", ex_imm, exp_ex.imm);
            if (exp_ex.valid) begin
                chk("ex_pc", ex_pc, exp_ex.pc);
                chk("ex_val_rn", ex_val_rn, exp_ex.vrn);
                chk("ex_val_src2", ex_val_src2, exp_ex.vs2);
                chk("ex_shift_op", ex_shift_op, exp_ex.shift);
                chk("ex_imm24", ex_imm24, exp_ex.imm24);
                chk("ex_dest", ex_dest, exp_ex.dest);
                chk("ex_src1", ex_src1, exp_ex.src1);
                chk("ex_src2", ex_src2, exp_ex.src2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v);
        instr_in = ins;
        in_valid = v;
        pc_in    = pc_in + 32'd4;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, ex_valid, 1'b0);
        chk({tag, "_cmd"}, ex_cmd, 4'h0);
        chk({tag, "_wb"}, ex_wb_en, 1'b0);
        chk({tag, "_mw"}, ex_mem_write, 1'b0);
        chk({tag, "_pc"}, ex_pc, 32'h0);
        chk({tag, "_vrn"}, ex_val_rn, 32'h0);
        chk({tag, "_dest"}, ex_dest, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        pc_in = 32'h100; instr_in = '0; in_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; nzcv = 4'h0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0;
        #1;
        chk_all_zero("por");
        @(negedge clk); #1 rst = 1'b0;
        step();
        chk("rel_valid", ex_valid, 1'b0);

        // Write-through bypass into ADD R1,R3,R3
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD_BEEF;
        drive(32'hE083_1003, 1'b1);
        step();
        wb_en = 1'b0;
        chk("byp_vrn", ex_val_rn, 32'hDEAD_BEEF);
        chk("byp_vs2", ex_val_src2, 32'hDEAD_BEEF);
        chk("byp_cmd", ex_cmd, 4'h2);
        chk("byp_wb", ex_wb_en, 1'b1);

        // ADDEQ with Z clear then set
        drive(32'h0083_1003, 1'b1); nzcv = 4'b0000;
        step();
        chk("eqf_valid", ex_valid, 1'b1);
        chk("eqf_cmd", ex_cmd, 4'h0);
        chk("eqf_wb", ex_wb_en, 1'b0);
        nzcv = 4'b0100;
        step();
        chk("eqt_cmd", ex_cmd, 4'h2);
        chk("eqt_wb", ex_wb_en, 1'b1);
        chk("eqt_vrn", ex_val_rn, 32'hDEAD_BEEF);

        // STR R2,[R1] then CMP R1,#5
        drive(32'hE581_2000, 1'b1);
        #1;
        chk("str_two", hz_two_src, 1'b1);
        chk("str_src2", hz_src2, 4'd2);
        step();
        chk("str_mw", ex_mem_write, 1'b1);
        chk("str_wb", ex_wb_en, 1'b0);
        drive(32'hE351_0005, 1'b1);
        #1;
        chk("cmp_two", hz_two_src, 1'b0);
        step();
        chk("cmp_cmd", ex_cmd, 4'h4);
        chk("cmp_s", ex_s, 1'b1);
        chk("cmp_wb", ex_wb_en, 1'b0);

        // MOV R1,#7 held by stall, then stall+flush
        drive(32'hE3A0_1007, 1'b1);
        step();
        chk("mov_cmd", ex_cmd, 4'h1);
        stall = 1'b1;
        drive(32'hE083_1003, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stl_cmd", ex_cmd, 4'h1);
            chk("stl_dest", ex_dest, 4'h1);
            chk("stl_imm", ex_imm, 1'b1);
        end
        flush = 1'b1;
        step();
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_wb", ex_wb_en, 1'b0);
        stall = 1'b0; flush = 1'b0;

        // B then LDR R4,[R1]
        drive(32'hEA00_0004, 1'b1);
        step();
        chk("b_br", ex_branch, 1'b1);
        chk("b_imm24", ex_imm24, 24'h000004);
        drive(32'hE591_4000, 1'b1);
        step();
        chk("ldr_mr", ex_mem_read, 1'b1);
        chk("ldr_wb", ex_wb_en, 1'b1);
        chk("ldr_dest", ex_dest, 4'd4);
        chk("ldr_br", ex_branch, 1'b0);

        // Register writes then reads through the model
        for (int r = 0; r < 16; r++) begin
            wb_en = 1'b1; wb_dest = 4'(r); wb_value = 32'h1000_0000 + 32'(r * 17);
            drive({4'hE, 8'h08, 4'(r), 4'h0, 8'h00, 4'(15 - r)}, 1'b1);
            step();
        end
        wb_en = 1'b0;
        drive(32'hE087_1005, 1'b1);
        step();
        chk("rd_r7", ex_val_rn, 32'h1000_0077);
        chk("rd_r5", ex_val_src2, 32'h1000_0055);

        // All condition codes against several flag patterns
        for (int f = 0; f < 4; f++) begin
            nzcv = (f == 0) ? 4'b0000 : (f == 1) ? 4'b0110 : (f == 2) ? 4'b1001 : 4'b1010;
            for (int c = 0; c < 16; c++) begin
                drive({4'(c), 28'h0831003}, 1'b1);
                step();
            end
        end
        nzcv = 4'h0;

        // Every data-processing opcode, mode 11, and a bubble
        for (int op = 0; op < 16; op++) begin
            drive({4'hE, 3'b000, 4'(op), 1'b1, 4'h2, 4'h6, 8'h00, 4'h9}, 1'b1);
            step();
        end
        drive(32'hEC12_3456, 1'b1);
        step();
        chk("m11_cmd", ex_cmd, 4'h0);
        drive(32'hE083_1003, 1'b0);
        step();
        chk("bub_valid", ex_valid, 1'b0);
        chk("bub_wb", ex_wb_en, 1'b0);

        // Reset in the middle of a valid instruction
        drive(32'hE083_1003, 1'b1);
        step();
        #2 rst = 1'b1;
        #1;
        chk_all_zero("mrst");
        @(negedge clk); #1 rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("mrst_rel", ex_valid, 1'b0);
        drive(32'hE083_1003, 1'b1);
        step();
        chk("mrst_reg", ex_val_rn, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
